// File: rtl/param_demux_router.sv
// Parametrised 1:CHANNELS stream router. Each output channel owns a DEPTH-entry
// FIFO, so a stalled consumer only blocks beats that are headed for its own
// channel. In broadcast mode a beat is pushed into every FIFO in one cycle, or
// into none of them.
module param_demux_router #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   parameter  int DEPTH    = 2,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [SEL_W-1:0]          in_sel,
   input  logic                      in_bcast,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [7:0]                err_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [SEL_W:0] CH_LIM = CHANNELS[SEL_W:0];

   logic [CHANNELS-1:0] full;
   logic [CHANNELS-1:0] empty;
   logic [CHANNELS-1:0] push;
   logic [CHANNELS-1:0] pop;
   logic                sel_ok;
   logic                sel_full;
   logic                accept;
   logic                drop;
   logic [7:0]          err_count_q;
   logic [7:0]          err_count_d;

   // Input readiness depends on FIFO full flags only, never on out_ready.
   // An out-of-range select is always accepted so it can be discarded.
   always_comb begin
      sel_ok   = ({1'b0, in_sel} < CH_LIM);
      sel_full = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (in_sel == SEL_W'(k)) sel_full = full[k];
      end
      if (in_bcast)     in_ready = ~(|full);
      else if (!sel_ok) in_ready = 1'b1;
      else              in_ready = ~sel_full;
      accept = in_valid & in_ready;
      drop   = accept & ~in_bcast & ~sel_ok;
   end

   // Saturating count of discarded out-of-range beats.
   always_comb begin
      err_count_d = err_count_q;
      if (drop && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
   end

   // Error counter register.
   always_ff @(posedge clk) begin
      if (reset) err_count_q <= '0;
      else       err_count_q <= err_count_d;
   end

   assign err_count = err_count_q;

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic [PW-1:0]    wr_ptr_q;
      logic [PW-1:0]    wr_ptr_d;
      logic [PW-1:0]    rd_ptr_q;
      logic [PW-1:0]    rd_ptr_d;
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [WIDTH-1:0] mem_d [DEPTH];

      // Pointers carry one extra wrap bit to tell full from empty.
      assign empty[k] = (wr_ptr_q == rd_ptr_q);
      assign full[k]  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

      // in_ready already guarantees this FIFO is not full when it is pushed.
      assign push[k] = accept & (in_bcast | (sel_ok & (in_sel == SEL_W'(k))));
      assign pop[k]  = ~empty[k] & out_ready[k];

      assign out_valid[k]              = ~empty[k];
      assign out_data[k*WIDTH +: WIDTH] = empty[k] ? '0 : mem_q[rd_ptr_q[AW-1:0]];

      // Next FIFO state: write at the tail on push, advance the head on pop.
      always_comb begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         mem_d    = mem_q;
         if (push[k]) begin
            mem_d[wr_ptr_q[AW-1:0]] = in_data;
            wr_ptr_d                = wr_ptr_q + PW'(1);
         end
         if (pop[k]) rd_ptr_d = rd_ptr_q + PW'(1);
      end

      // FIFO registers; reset discards everything buffered.
      always_ff @(posedge clk) begin
         if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
         end
      end
   end

endmodule

// File: tb/tb_param_demux_router.sv
// Bench for param_demux_router: a 4-channel instance checked against per-channel
// queue model, plus a 3-channel instance for out-of-range select handling.
module tb_param_demux_router;
   localparam int D = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic        iv4, rdy4, bc4;
   logic [7:0]  din4;
   logic [1:0]  sel4;
   logic [3:0]  ov4, or4;
   logic [31:0] od4;
   logic [7:0]  err4;

   logic        iv3, rdy3, bc3;
   logic [7:0]  din3;
   logic [1:0]  sel3;
   logic [2:0]  ov3, or3;
   logic [23:0] od3;
   logic [7:0]  err3;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] mq [4][8];
   int         mcnt [4];
   int         merr3;

   always #5 clk = ~clk;

   param_demux_router #(.WIDTH(8), .CHANNELS(4), .DEPTH(D)) dut4 (
      .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(rdy4), .in_data(din4),
      .in_sel(sel4), .in_bcast(bc4), .out_valid(ov4), .out_ready(or4),
      .out_data(od4), .err_count(err4));

   param_demux_router #(.WIDTH(8), .CHANNELS(3), .DEPTH(D)) dut3 (
      .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(rdy3), .in_data(din3),
      .in_sel(sel3), .in_bcast(bc3), .out_valid(ov3), .out_ready(or3),
      .out_data(od3), .err_count(err3));

   function automatic logic m_ready(input logic b, input logic [1:0] s);
      if (b) return (mcnt[0] < D) && (mcnt[1] < D) && (mcnt[2] < D) && (mcnt[3] < D);
      return mcnt[s] < D;
   endfunction

   function automatic logic [3:0] m_valid();
      logic [3:0] v;
      for (int k = 0; k < 4; k++) v[k] = (mcnt[k] > 0);
      return v;
   endfunction

   function automatic logic [31:0] m_data();
      logic [31:0] d;
      d = '0;
      for (int k = 0; k < 4; k++) if (mcnt[k] > 0) d[k*8 +: 8] = mq[k][0];
      return d;
   endfunction

   function automatic void m_push(input int k, input logic [7:0] v);
      if (mcnt[k] < 8) begin
         mq[k][mcnt[k]] = v;
         mcnt[k]++;
      end
   endfunction

   function automatic void m_pop(input int k);
      for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
      mcnt[k]--;
   endfunction

   function automatic void m_clear();
      for (int k = 0; k < 4; k++) mcnt[k] = 0;
      merr3 = 0;
   endfunction

   // Advance one clock and update the model from the inputs seen at the edge.
   task automatic tick();
      logic       acc;
      logic [3:0] pops;
      logic       drop3;
      acc   = iv4 && m_ready(bc4, sel4);
      pops  = m_valid() & or4;
      drop3 = iv3 && !bc3 && (sel3 == 2'd3);
      @(posedge clk);
      if (reset) m_clear();
      else begin
         for (int k = 0; k < 4; k++) if (pops[k]) m_pop(k);
         if (acc) begin
            if (bc4) for (int k = 0; k < 4; k++) m_push(k, din4);
            else     m_push(int'(sel4), din4);
         end
         if (drop3 && merr3 < 255) merr3++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      tests_run++; if (ov4 !== 4'b0) begin tests_failed++; $display("FAIL reset_ov4 got %b want 0", ov4); end
      tests_run++; if (od4 !== 32'h0) begin tests_failed++; $display("FAIL reset_od4 got %h want 0", od4); end
      tests_run++; if (err4 !== 8'h0) begin tests_failed++; $display("FAIL reset_err4 got %0d want 0", err4); end
      tests_run++; if (rdy4 !== 1'b1) begin tests_failed++; $display("FAIL reset_rdy4 got %b want 1", rdy4); end
      tests_run++; if (ov3 !== 3'b0 || err3 !== 8'h0) begin tests_failed++; $display("FAIL reset_dut3 got ov %b err %0d want 0/0", ov3, err3); end
   endtask

   task automatic test_unicast();
      or4 = 4'hF; iv4 = 1'b1; sel4 = 2'd2; din4 = 8'hA5; bc4 = 1'b0;
      #1;
      tests_run++; if (rdy4 !== 1'b1) begin tests_failed++; $display("FAIL uni_rdy got %b want 1", rdy4); end
      tick();
      iv4 = 1'b0;
      #1;
      tests_run++; if (ov4 !== 4'b0100) begin tests_failed++; $display("FAIL uni_ov got %b want 0100", ov4); end
      tests_run++; if (od4[23:16] !== 8'hA5) begin tests_failed++; $display("FAIL uni_data got %h want a5", od4[23:16]); end
      tests_run++; if ({od4[31:24], od4[15:0]} !== 24'h0) begin tests_failed++; $display("FAIL uni_other got %h want 0", od4); end
      tick();
      #1;
      tests_run++; if (ov4 !== 4'b0) begin tests_failed++; $display("FAIL uni_pop got %b want 0", ov4); end
   endtask

   task automatic test_backpressure();
      logic [7:0] vals [3];
      logic [7:0] log_v [8];
      int         nlog;
      logic       sent;
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      or4 = 4'b1101; bc4 = 1'b0; sel4 = 2'd1; iv4 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din4 = vals[i];
         #1;
         tests_run++;
         if (rdy4 !== (i < 2)) begin tests_failed++; $display("FAIL bp_rdy beat %0d got %b want %b", i, rdy4, (i < 2)); end
         tick();
      end
      sel4 = 2'd0; din4 = 8'h44;
      #1;
      tests_run++; if (rdy4 !== 1'b1) begin tests_failed++; $display("FAIL bp_ch0 got %b want 1", rdy4); end
      tick();
      sel4 = 2'd1; din4 = 8'h33; or4 = 4'hF; sent = 1'b0; nlog = 0;
      for (int c = 0; c < 6; c++) begin
         iv4 = !sent;
         #1;
         tests_run++; if (rdy4 !== m_ready(bc4, sel4)) begin tests_failed++; $display("FAIL bp_drain_rdy cyc %0d got %b want %b", c, rdy4, m_ready(bc4, sel4)); end
         tests_run++; if (ov4 !== m_valid() || od4 !== m_data()) begin tests_failed++; $display("FAIL bp_drain_out cyc %0d got %b/%h want %b/%h", c, ov4, od4, m_valid(), m_data()); end
         if (ov4[1] && nlog < 8) begin log_v[nlog] = od4[15:8]; nlog++; end
         if (iv4 && rdy4) sent = 1'b1;
         tick();
      end
      iv4 = 1'b0;
      tests_run++;
      if (nlog != 3 || log_v[0] !== 8'h11 || log_v[1] !== 8'h22 || log_v[2] !== 8'h33) begin
         tests_failed++; $display("FAIL bp_order got n=%0d %h %h %h want 3 11 22 33", nlog, log_v[0], log_v[1], log_v[2]);
      end
   endtask

   task automatic test_bcast_full();
      or4 = 4'b0111; bc4 = 1'b0; sel4 = 2'd3; iv4 = 1'b1;
      din4 = 8'hA1; tick();
      din4 = 8'hA2; tick();
      bc4 = 1'b1; din4 = 8'h5C;
      for (int c = 0; c < 2; c++) begin
         #1;
         tests_run++; if (rdy4 !== 1'b0) begin tests_failed++; $display("FAIL bc_blocked_rdy got %b want 0", rdy4); end
         tests_run++; if (ov4 !== 4'b1000 || od4[31:24] !== 8'hA1) begin tests_failed++; $display("FAIL bc_nochange got %b/%h want 1000/a1", ov4, od4[31:24]); end
         tick();
      end
      iv4 = 1'b0; or4 = 4'hF;
      tick(); tick();
      or4 = 4'h0; iv4 = 1'b1;
      #1;
      tests_run++; if (rdy4 !== 1'b1) begin tests_failed++; $display("FAIL bc_free_rdy got %b want 1", rdy4); end
      tick();
      iv4 = 1'b0; bc4 = 1'b0;
      #1;
      tests_run++; if (ov4 !== 4'hF || od4 !== {4{8'h5C}}) begin tests_failed++; $display("FAIL bc_all got %b/%h want 1111/5c5c5c5c", ov4, od4); end
      or4 = 4'hF;
      tick();
   endtask

   task automatic test_wrap();
      logic [7:0] sent_v [8];
      logic [7:0] got_v [8];
      int         ngot;
      ngot = 0; or4 = 4'hF; bc4 = 1'b0; sel4 = 2'd0;
      for (int i = 0; i < 2*D + 2; i++) begin
         iv4 = (i < 2*D + 1);
         din4 = 8'($urandom);
         if (iv4) sent_v[i] = din4;
         #1;
         tests_run++; if (rdy4 !== m_ready(bc4, sel4)) begin tests_failed++; $display("FAIL wrap_rdy cyc %0d got %b want %b", i, rdy4, m_ready(bc4, sel4)); end
         tests_run++; if (ov4 !== m_valid() || od4 !== m_data()) begin tests_failed++; $display("FAIL wrap_out cyc %0d got %b/%h want %b/%h", i, ov4, od4, m_valid(), m_data()); end
         if (i > 0) begin
            tests_run++; if (ov4[0] !== 1'b1) begin tests_failed++; $display("FAIL wrap_occ cyc %0d got %b want 1", i, ov4[0]); end
         end
         if (ov4[0]) begin got_v[ngot] = od4[7:0]; ngot++; end
         tick();
      end
      iv4 = 1'b0;
      tests_run++; if (ngot != 2*D + 1) begin tests_failed++; $display("FAIL wrap_count got %0d want %0d", ngot, 2*D + 1); end
      for (int i = 0; i < ngot && i < 2*D + 1; i++) begin
         tests_run++; if (got_v[i] !== sent_v[i]) begin tests_failed++; $display("FAIL wrap_order idx %0d got %h want %h", i, got_v[i], sent_v[i]); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         iv4  = 1'($urandom);
         sel4 = 2'($urandom);
         bc4  = ($urandom_range(0, 5) == 0);
         din4 = 8'($urandom);
         or4  = 4'($urandom);
         #1;
         tests_run++; if (rdy4 !== m_ready(bc4, sel4)) begin tests_failed++; $display("FAIL rand_rdy cyc %0d got %b want %b", c, rdy4, m_ready(bc4, sel4)); end
         tests_run++; if (ov4 !== m_valid()) begin tests_failed++; $display("FAIL rand_valid cyc %0d got %b want %b", c, ov4, m_valid()); end
         tests_run++; if (od4 !== m_data()) begin tests_failed++; $display("FAIL rand_data cyc %0d got %h want %h", c, od4, m_data()); end
         tick();
      end
      iv4 = 1'b0; bc4 = 1'b0; or4 = 4'hF;
      tick(); tick(); tick();
      #1;
      tests_run++; if (ov4 !== 4'b0 || err4 !== 8'h0) begin tests_failed++; $display("FAIL rand_drain got %b err %0d want 0/0", ov4, err4); end
   endtask

   task automatic test_err3();
      or3 = 3'b111; iv3 = 1'b1; sel3 = 2'd3; bc3 = 1'b0;
      for (int i = 0; i < 300; i++) begin
         din3 = 8'($urandom);
         #1;
         tests_run++; if (rdy3 !== 1'b1) begin tests_failed++; $display("FAIL err_rdy beat %0d got %b want 1", i, rdy3); end
         tick();
         #1;
         tests_run++; if (ov3 !== 3'b0) begin tests_failed++; $display("FAIL err_novalid beat %0d got %b want 0", i, ov3); end
         tests_run++; if (err3 !== 8'(merr3)) begin tests_failed++; $display("FAIL err_count beat %0d got %0d want %0d", i, err3, merr3); end
      end
      tests_run++; if (err3 !== 8'd255) begin tests_failed++; $display("FAIL err_sat got %0d want 255", err3); end
      sel3 = 2'd2; din3 = 8'h77; or3 = 3'b000;
      tick();
      iv3 = 1'b0;
      #1;
      tests_run++; if (ov3 !== 3'b100 || od3 !== 24'h770000 || err3 !== 8'd255) begin tests_failed++; $display("FAIL err_ch2 got %b/%h/%0d want 100/770000/255", ov3, od3, err3); end
   endtask

   task automatic test_reset_mid();
      or4 = 4'h0; bc4 = 1'b0; iv4 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sel4 = 2'(k); din4 = 8'($urandom);
         tick();
      end
      #1;
      tests_run++; if (ov4 !== m_valid() || ov4 !== 4'hF) begin tests_failed++; $display("FAIL mid_fill got %b want 1111", ov4); end
      sel4 = 2'd3; din4 = 8'hEE; iv3 = 1'b1; sel3 = 2'd3;
      reset = 1'b1;
      tick();
      reset = 1'b0; iv4 = 1'b0; iv3 = 1'b0;
      #1;
      tests_run++; if (ov4 !== 4'b0 || od4 !== 32'h0) begin tests_failed++; $display("FAIL mid_out got %b/%h want 0/0", ov4, od4); end
      tests_run++; if (rdy4 !== 1'b1) begin tests_failed++; $display("FAIL mid_rdy got %b want 1", rdy4); end
      tests_run++; if (ov3 !== 3'b0 || od3 !== 24'h0 || err3 !== 8'h0) begin tests_failed++; $display("FAIL mid_dut3 got %b/%h/%0d want 0/0/0", ov3, od3, err3); end
      tick();
      #1;
      tests_run++; if (ov4 !== 4'b0) begin tests_failed++; $display("FAIL mid_nolate got %b want 0", ov4); end
   endtask

   initial begin
      iv4 = 1'b0; bc4 = 1'b0; din4 = '0; sel4 = '0; or4 = 4'hF;
      iv3 = 1'b0; bc3 = 1'b0; din3 = '0; sel3 = '0; or3 = 3'b111;
      m_clear();
      test_reset();
      test_unicast();
      test_backpressure();
      test_bcast_full();
      test_wrap();
      test_random();
      test_err3();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/param_demux_router.md
Name: param_demux_router

Overview:
- Parametrised, buffered successor to the fixed-width 1:4 demux.
- Routes a WIDTH-bit input stream to one of CHANNELS output streams (or to all, in broadcast mode), using valid/ready handshakes on every port.
- Each output channel has its own DEPTH-entry FIFO, so one stalled consumer does not block traffic to the other channels.
- Sits between the datapath producer and per-unit consumers in the term-project datapath.

Parameters:
WIDTH, 8, data bits per beat
CHANNELS, 4, number of output channels (2..16)
DEPTH, 2, per-channel FIFO entries (power of 2, >=2)
SEL_W, $clog2(CHANNELS), select width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept the current beat
in_data  input  WIDTH  input beat payload
in_sel  input  SEL_W  destination channel index
in_bcast  input  1  1 = deliver the beat to all channels, ignoring in_sel
out_valid  output  CHANNELS  per-channel head valid
out_ready  input  CHANNELS  per-channel consumer ready
out_data  output  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
err_count  output  8  count of discarded out-of-range beats, saturating

Behaviour:
- Reset (synchronous, sampled on the rising clk edge while reset=1):
  - All FIFOs empty; out_valid=0; out_data=0; err_count=0.
  - Reset overrides any handshake in the same cycle, including a reset asserted mid-transfer. In-flight and buffered beats are discarded.
- Accept: a beat is accepted on the cycle where in_valid && in_ready = 1.
- in_ready is combinational from FIFO full flags only, never from out_ready:
  - Unicast, in_sel < CHANNELS: in_ready = !full[in_sel].
  - Broadcast: in_ready = no FIFO full. The beat is pushed into every FIFO atomically, or into none.
  - Unicast, in_sel >= CHANNELS (possible only when CHANNELS is not a power of 2): in_ready=1. The beat is discarded and err_count increments; it holds at 255.
- Latency: a beat accepted at edge N is visible as out_valid[k]=1 with its data after edge N (1-cycle latency), provided FIFO k was empty.
- Pop: channel k pops its head on the edge where out_valid[k] && out_ready[k] = 1. Data is delivered in order within a channel. There is no ordering guarantee across channels.
- out_data slice k equals the head entry while out_valid[k]=1, and is forced to 0 while out_valid[k]=0.
- Simultaneous push and pop on the same channel:
  - Allowed when the FIFO is not full; occupancy is unchanged.
  - A full FIFO refuses the push even if it pops in the same cycle (no pass-through), so in_ready stays 0 for that cycle.
- An empty FIFO never forwards the input combinationally to its output.
- Per-channel FIFO:
  - Circular buffer with read/write pointers of $clog2(DEPTH)+1 bits.
  - full = MSBs differ and the low bits are equal; empty = pointers are equal.
  - Pointers wrap at DEPTH with no gap.
- in_data, in_sel and in_bcast are sampled only on accept. Their values while in_valid=0 have no effect.
- No internal state machine beyond the FIFO pointers and the err_count saturating counter. Implement per-channel logic with a generate loop.

Test Plan:
- Reset, then unicast to channel 2, data 8'hA5, all out_ready=1 -> out_valid=4'b0100 with out_data[23:16]=8'hA5 one cycle later; popped the next edge; other slices read 0.
- Hold out_ready[1]=0 and send 3 beats to ch1 (11,22,33) -> first 2 accepted; in_ready=0 on the third; ch0 traffic is still accepted. Raise out_ready[1] -> 11,22 out in order, then 33 accepted.
- Broadcast 8'h5C while ch3 FIFO is full -> in_ready=0, and no FIFO changes. Free ch3 -> all four channels present 8'h5C on the same cycle.
- Channel with 1 entry and out_ready=1, push a new beat the same cycle -> occupancy stays 1; the new data reaches the head the next cycle. Cycle 2*DEPTH+1 beats through to check pointer wrap ordering.
- CHANNELS=3: send in_sel=3 three hundred times -> all accepted; no out_valid rises; err_count saturates at 255.
- Assert reset mid-stream with all FIFOs partially full -> the next cycle shows out_valid=0, out_data=0, err_count=0, in_ready=1.
